ethernet_tx_frame_builder: RTL and testbench

Builds Ethernet II frames for the transmit path. It accepts a raw payload stream, prepends the 14-byte header (destination MAC, source MAC, EtherType) and re-aligns the payload across 64-bit beats. Frames shorter than the 60-byte minimum are optionally zero-padded. It sits directly upstream of the Ethernet controller AXI-Stream bridge and drives its controller-side TX input, which has no ready signal.

---
 rtl/ethernet_tx_frame_builder.sv | 219 +++++++++++++++++++++
 tb/tb_ethernet_tx_frame_builder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_tx_frame_builder.sv
// rtl/ethernet_tx_frame_builder.sv - Ethernet II header insertion and 64-bit beat re-alignment
// Define ETH_TX_PAD_EN to zero-pad frames shorter than 60 bytes.
module ethernet_tx_frame_builder (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [47:0] i_dst_mac,
  input  logic [47:0] i_src_mac,
  input  logic [15:0] i_ethertype,
  input  logic        i_pl_tvalid,
  output logic        o_pl_tready,
  input  logic [63:0] i_pl_tdata,
  input  logic        i_pl_tlast,
  input  logic [7:0]  i_pl_tkeep,
  output logic        o_tx_contr_tvalid,
  output logic [63:0] o_tx_contr_tdata,
  output logic        o_tx_contr_tlast,
  output logic [7:0]  o_tx_contr_tkeep,
  output logic        o_frame_done,
  output logic        o_underrun
);

`ifdef ETH_TX_PAD_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_TAIL, S_PAD} state_e;
  localparam logic [11:0] MIN_FRAME = 12'd60;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_TAIL} state_e;
`endif

  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    return (n >= 4'd8) ? 8'hFF : 8'((9'd1 << n) - 9'd1);
  endfunction

  function automatic logic [3:0] keep_count(input logic [7:0] k);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) if (k[i]) c = 4'(i + 1);
    return c;
  endfunction

  function automatic logic [63:0] lane_mask(input logic [3:0] n);
    logic [7:0]  m;
    logic [63:0] r;
    r = '0;
    m = keep_mask(n);
    for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  state_e      state_q, state_d, end_state;
  logic [47:0] dst_q, src_q, hold_q, hold_d;
  logic [15:0] type_q;
  logic [10:0] cnt_q, cnt_d;
  logic [2:0]  tail_q, tail_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d, underrun_q, underrun_d;
  logic [63:0] tdata_q, tdata_d;
  logic [7:0]  tkeep_q, tkeep_d;

  logic [3:0]  kb;
  logic        beat_en, data_end, last;
  logic [3:0]  nbytes, eff;
  logic [63:0] raw;
  logic [11:0] sum;
`ifdef ETH_TX_PAD_EN
  logic        to_pad;
  logic [11:0] total, room;
`endif

  assign kb          = keep_count(i_pl_tkeep);
  assign o_pl_tready = (state_q == S_HDR1) || (state_q == S_DATA);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      tail_q     <= '0;
      dst_q      <= '0;
      src_q      <= '0;
      type_q     <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      tkeep_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      tail_q     <= tail_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      tkeep_q    <= tkeep_d;
      underrun_q <= underrun_d;
      if (state_q == S_IDLE && i_pl_tvalid) begin
        dst_q  <= i_dst_mac;
        src_q  <= i_src_mac;
        type_q <= i_ethertype;
      end
    end
  end

  // Beat formation: each state's beat is what the output register loads at its closing edge.
  always_comb begin
    raw        = '0;
    nbytes     = 4'd0;
    beat_en    = 1'b0;
    data_end   = 1'b0;
    underrun_d = 1'b0;
    case (state_q)
      S_HDR0: begin
        beat_en = 1'b1;
        nbytes  = 4'd8;
        raw     = {src_q[39:32], src_q[47:40], dst_q[7:0], dst_q[15:8],
                   dst_q[23:16], dst_q[31:24], dst_q[39:32], dst_q[47:40]};
      end
      S_HDR1, S_DATA: begin
        if (i_pl_tvalid) begin
          beat_en      = 1'b1;
          raw[63:48]   = i_pl_tdata[15:0];
          raw[47:0]    = (state_q == S_HDR1) ?
                         {type_q[7:0], type_q[15:8], src_q[7:0], src_q[15:8],
                          src_q[23:16], src_q[31:24]} : hold_q;
          if (i_pl_tlast && kb <= 4'd2) begin
            data_end = 1'b1;
            nbytes   = 4'd6 + kb;
          end else begin
            nbytes   = 4'd8;
          end
        end else begin
          underrun_d = 1'b1;
        end
      end
      S_TAIL: begin
        beat_en  = 1'b1;
        data_end = 1'b1;
        raw      = {16'd0, hold_q};
        nbytes   = {1'b0, tail_q};
      end
`ifdef ETH_TX_PAD_EN
      S_PAD: begin
        beat_en  = 1'b1;
        data_end = 1'b1;
      end
`endif
      default: ;
    endcase

    eff  = nbytes;
    last = data_end;
`ifdef ETH_TX_PAD_EN
    // Short frames: fill the rest of this beat with zeros, continue in PAD if 60 is not yet reached.
    to_pad = 1'b0;
    total  = {1'b0, cnt_q} + {8'd0, nbytes};
    room   = MIN_FRAME - {1'b0, cnt_q};
    if (data_end && total < MIN_FRAME) begin
      if (room <= 12'd8) begin
        eff = room[3:0];
      end else begin
        eff    = 4'd8;
        last   = 1'b0;
        to_pad = 1'b1;
      end
    end
`endif

    tvalid_d = beat_en;
    tlast_d  = beat_en & last;
    tdata_d  = raw & lane_mask(nbytes);
    tkeep_d  = !beat_en ? 8'h00 : (last ? keep_mask(eff) : 8'hFF);
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
`ifdef ETH_TX_PAD_EN
    end_state = to_pad ? S_PAD : S_IDLE;
`else
    end_state = S_IDLE;
`endif
    sum = {1'b0, cnt_q} + {8'd0, eff};
    if (beat_en) cnt_d = sum[11] ? 11'h7FF : sum[10:0];
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (i_pl_tvalid) state_d = S_HDR0;
      end
      S_HDR0: state_d = S_HDR1;
      S_HDR1, S_DATA: begin
        if (i_pl_tvalid) begin
          hold_d = i_pl_tdata[63:16];
          if (!i_pl_tlast) begin
            state_d = S_DATA;
          end else if (kb > 4'd2) begin
            state_d = S_TAIL;
            tail_d  = 3'(kb - 4'd2);
          end else begin
            state_d = end_state;
          end
        end
      end
      S_TAIL: state_d = end_state;
`ifdef ETH_TX_PAD_EN
      S_PAD: if (last) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign o_tx_contr_tvalid = tvalid_q;
  assign o_tx_contr_tdata  = tdata_q;
  assign o_tx_contr_tlast  = tlast_q;
  assign o_tx_contr_tkeep  = tkeep_q;
  assign o_frame_done      = tlast_q;
  assign o_underrun        = underrun_q;

endmodule

// File: tb/tb_ethernet_tx_frame_builder.sv
// tb/tb_ethernet_tx_frame_builder.sv - randomized self-checking bench for ethernet_tx_frame_builder
// Reference frame is built as a byte list (header + payload [+ pad]) and cut into 8-byte beats.
module tb_ethernet_tx_frame_builder;
  logic        clk;
  logic        i_reset;
  logic [47:0] i_dst_mac, i_src_mac;
  logic [15:0] i_ethertype;
  logic        i_pl_tvalid, o_pl_tready, i_pl_tlast;
  logic [63:0] i_pl_tdata;
  logic [7:0]  i_pl_tkeep;
  logic        o_tx_contr_tvalid, o_tx_contr_tlast, o_frame_done, o_underrun;
  logic [63:0] o_tx_contr_tdata;
  logic [7:0]  o_tx_contr_tkeep;

  ethernet_tx_frame_builder dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_dst_mac(i_dst_mac), .i_src_mac(i_src_mac), .i_ethertype(i_ethertype),
    .i_pl_tvalid(i_pl_tvalid), .o_pl_tready(o_pl_tready), .i_pl_tdata(i_pl_tdata),
    .i_pl_tlast(i_pl_tlast), .i_pl_tkeep(i_pl_tkeep),
    .o_tx_contr_tvalid(o_tx_contr_tvalid), .o_tx_contr_tdata(o_tx_contr_tdata),
    .o_tx_contr_tlast(o_tx_contr_tlast), .o_tx_contr_tkeep(o_tx_contr_tkeep),
    .o_frame_done(o_frame_done), .o_underrun(o_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0] hdr_dst, hdr_src;
  logic [15:0] hdr_type;
  logic [7:0]  pl_q[$];
  logic [7:0]  exp_q[$];

  logic [63:0] mon_data[$];
  logic [7:0]  mon_keep[$];
  logic        mon_last[$];
  int          done_cnt, underrun_cnt, bubble_cnt, fd_err;
  logic        in_frame;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    mon_data.delete();
    mon_keep.delete();
    mon_last.delete();
    done_cnt = 0; underrun_cnt = 0; bubble_cnt = 0; fd_err = 0;
    in_frame = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (o_tx_contr_tvalid) begin
      mon_data.push_back(o_tx_contr_tdata);
      mon_keep.push_back(o_tx_contr_tkeep);
      mon_last.push_back(o_tx_contr_tlast);
      in_frame = !o_tx_contr_tlast;
    end else if (in_frame) begin
      bubble_cnt++;
    end
    if (o_underrun) underrun_cnt++;
    if (o_frame_done) done_cnt++;
    if (o_frame_done != (o_tx_contr_tvalid & o_tx_contr_tlast)) fd_err++;
  end

  function automatic logic [63:0] keep_to_mask(input logic [7:0] k);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic build_exp();
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(hdr_dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) exp_q.push_back(hdr_src[47-8*i -: 8]);
    exp_q.push_back(hdr_type[15:8]);
    exp_q.push_back(hdr_type[7:0]);
    foreach (pl_q[i]) exp_q.push_back(pl_q[i]);
`ifdef ETH_TX_PAD_EN
    while (exp_q.size() < 60) exp_q.push_back(8'h00);
`endif
  endtask

  task automatic set_payload(input int n, input bit incr);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(incr ? 8'(i) : 8'($urandom));
  endtask

  task automatic drive_frame(input int gap_at, input int gap_len, input int rst_at);
    int n, nin, idx, gl, guard;
    n = pl_q.size(); nin = (n + 7) / 8; idx = 0; gl = gap_len; guard = 0;
    i_dst_mac = hdr_dst; i_src_mac = hdr_src; i_ethertype = hdr_type;
    while (idx < nin && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (rst_at >= 0 && mon_data.size() >= rst_at) begin
        i_reset = 1'b1; i_pl_tvalid = 1'b0;
        @(negedge clk);
        i_reset = 1'b0;
        return;
      end
      if (idx == gap_at && gl > 0 && o_pl_tready) begin
        i_pl_tvalid = 1'b0;
        gl--;
      end else begin
        i_pl_tvalid = 1'b1;
        i_pl_tlast  = (idx == nin - 1);
        i_pl_tdata  = '0;
        i_pl_tkeep  = '0;
        for (int j = 0; j < 8; j++) begin
          if (8*idx + j < n) begin
            i_pl_tdata[8*j +: 8] = pl_q[8*idx + j];
            i_pl_tkeep[j] = 1'b1;
          end
        end
        if (o_pl_tready) begin
          idx++;
          i_dst_mac   = 48'({$urandom(), $urandom()});
          i_src_mac   = 48'({$urandom(), $urandom()});
          i_ethertype = 16'($urandom());
        end
      end
    end
    check("drv_beats_sent", idx, nin);
    @(negedge clk);
    i_pl_tvalid = 1'b0;
    i_pl_tlast  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int exp_under);
    int waited, nb;
    logic [63:0] ed;
    logic [7:0]  ek;
    waited = 0;
    while (done_cnt == 0 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    build_exp();
    nb = (exp_q.size() + 7) / 8;
    check({tag, ":done"}, done_cnt, 1);
    check({tag, ":beats"}, mon_data.size(), nb);
    for (int b = 0; b < nb && b < mon_data.size(); b++) begin
      ed = '0; ek = '0;
      for (int j = 0; j < 8; j++) begin
        if (8*b + j < exp_q.size()) begin
          ed[8*j +: 8] = exp_q[8*b + j];
          ek[j] = 1'b1;
        end
      end
      check($sformatf("%s:data%0d", tag, b), mon_data[b] & keep_to_mask(mon_keep[b]), ed);
      check($sformatf("%s:keep%0d", tag, b), mon_keep[b], ek);
      check($sformatf("%s:last%0d", tag, b), mon_last[b], b == nb - 1);
    end
    check({tag, ":underrun"}, underrun_cnt, exp_under);
    check({tag, ":bubbles"}, bubble_cnt, exp_under);
    check({tag, ":done_vs_tlast"}, fd_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n, nin, ga, gl;
    i_reset = 1'b1; i_pl_tvalid = 1'b0; i_pl_tlast = 1'b0;
    i_pl_tdata = '0; i_pl_tkeep = '0;
    i_dst_mac = '0; i_src_mac = '0; i_ethertype = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst:tvalid", o_tx_contr_tvalid, 0);
    check("rst:tdata", o_tx_contr_tdata, 0);
    check("rst:tlast", o_tx_contr_tlast, 0);
    check("rst:tkeep", o_tx_contr_tkeep, 0);
    check("rst:done", o_frame_done, 0);
    check("rst:underrun", o_underrun, 0);
    check("rst:tready", o_pl_tready, 0);
    i_reset = 1'b0;
    @(negedge clk);

    hdr_dst = 48'h001122334455; hdr_src = 48'h66778899AABB; hdr_type = 16'h0800;
    set_payload(64, 1'b1);
    clear_mon(); drive_frame(-1, 0, -1); check_frame("tp64", 0);
    check("tp64:beat0", mon_data[0], 64'h7766554433221100);
    check("tp64:beat1", mon_data[1], 64'h01000008BBAA9988);
    check("tp64:lastkeep", mon_keep[mon_keep.size()-1], 8'h3F);
    check("tp64:nbeats", mon_data.size(), 10);

    pl_q.delete(); pl_q.push_back(8'hA5);
    clear_mon(); drive_frame(-1, 0, -1); check_frame("one", 0);
    check("one:byte14", mon_data[1][55:48], 8'hA5);
`ifdef ETH_TX_PAD_EN
    check("one:nbeats", mon_data.size(), 8);
    check("one:lastkeep", mon_keep[mon_keep.size()-1], 8'h0F);
`else
    check("one:nbeats", mon_data.size(), 2);
    check("one:lastkeep", mon_keep[mon_keep.size()-1], 8'h7F);
`endif

    set_payload(46, 1'b0);
    clear_mon(); drive_frame(-1, 0, -1); check_frame("p46", 0);
    check("p46:nbeats", mon_data.size(), 8);
    check("p46:lastkeep", mon_keep[mon_keep.size()-1], 8'h0F);

    set_payload(24, 1'b0);
    clear_mon(); drive_frame(1, 2, -1); check_frame("gap24", 2);
`ifndef ETH_TX_PAD_EN
    check("gap24:nbeats", mon_data.size(), 5);
`endif

    set_payload(64, 1'b0);
    clear_mon(); drive_frame(-1, 0, 4);
    check("midrst:tvalid", o_tx_contr_tvalid, 0);
    check("midrst:tdata", o_tx_contr_tdata, 0);
    check("midrst:tlast", o_tx_contr_tlast, 0);
    check("midrst:tkeep", o_tx_contr_tkeep, 0);
    check("midrst:tready", o_pl_tready, 0);
    check("midrst:no_done", done_cnt, 0);
    @(negedge clk);
    hdr_dst = 48'($urandom()); hdr_src = 48'({$urandom(), $urandom()}); hdr_type = 16'h86DD;
    set_payload(8, 1'b0);
    clear_mon(); drive_frame(-1, 0, -1); check_frame("after_rst", 0);

    for (int f = 0; f < 25; f++) begin
      hdr_dst  = 48'({$urandom(), $urandom()});
      hdr_src  = 48'({$urandom(), $urandom()});
      hdr_type = 16'($urandom());
      n   = $urandom_range(1, 120);
      nin = (n + 7) / 8;
      set_payload(n, 1'b0);
      ga = -1; gl = 0;
      if (nin > 1 && $urandom_range(0, 3) == 0) begin
        ga = $urandom_range(1, nin - 1);
        gl = $urandom_range(1, 3);
      end
      clear_mon(); drive_frame(ga, gl, -1);
      check_frame($sformatf("rnd%0d_n%0d", f, n), gl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
